// File: rtl/divider_datapath.sv
// ---------------------------------------------------------------------------
// divider_datapath
//
// Datapath for an 8-bit unsigned restoring divider. An external sequencer
// drives the control inputs. Each quotient bit takes two cycles: a trial
// subtract, then either a restore or a keep that also shifts.
//
// Ports
//   clk          : clock, rising-edge
//   reset        : synchronous, active-low reset
//   load         : capture operands and start a new division (beats all but reset)
//   add          : ALU op select, 1 = R+D, 0 = R-D
//   shift        : shift R/A/Q left by one this cycle
//   inbit        : quotient bit shifted into Q lsb on shift
//   sel[1:0]     : remainder source, 0 hold, 1 ALU, 2 clear, 3 keep
//   dividend[7:0]: unsigned dividend, sampled on load
//   divisor[7:0] : unsigned divisor, sampled on load
//   sign         : R[9], sign of the partial remainder register
//   quotient[7:0], remainder[7:0] : captured result
//   result_valid : quotient/remainder hold a completed result
//   div_by_zero  : divisor captured on the last load was zero
// ---------------------------------------------------------------------------
module divider_datapath (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       add,
    input  logic       shift,
    input  logic       inbit,
    input  logic [1:0] sel,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       sign,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       result_valid,
    output logic       div_by_zero
);

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_ALU   = 2'd1;
    localparam logic [1:0] SEL_CLEAR = 2'd2;
    localparam logic [1:0] SEL_KEEP  = 2'd3;

    localparam logic [3:0] LAST_BIT  = 4'd7;
    localparam logic [3:0] CNT_DONE  = 4'd8;

    // Partial remainder is 10 bits. With a restored remainder below D (at most
    // 255), the shifted value stays below 512, so R-D lies in -255..510 and
    // bit 9 is a true sign bit.
    logic [9:0] r_q;
    logic [7:0] a_q;
    logic [7:0] d_q;
    logic [7:0] q_q;
    logic [3:0] cnt_q;

    logic [9:0] r_next;
    logic [9:0] alu_out;

    // ALU: add or subtract the zero-extended divisor, modulo 2^10.
    always_comb begin
        alu_out = add ? (r_q + {2'b00, d_q}) : (r_q - {2'b00, d_q});
    end

    // Remainder source mux, before any shift.
    always_comb begin
        r_next = r_q;
        case (sel)
            SEL_HOLD:  r_next = r_q;
            SEL_ALU:   r_next = alu_out;
            SEL_CLEAR: r_next = 10'd0;
            SEL_KEEP:  r_next = r_q;
            default:   r_next = r_q;
        endcase
    end

    // sign comes from the register itself. The sequencer reads it in the cycle
    // after the trial subtract lands in R.
    assign sign = r_q[9];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q          <= 10'd0;
            a_q          <= 8'd0;
            d_q          <= 8'd0;
            q_q          <= 8'd0;
            cnt_q        <= 4'd0;
            quotient     <= 8'd0;
            remainder    <= 8'd0;
            result_valid <= 1'b0;
            div_by_zero  <= 1'b0;
        end else if (load) begin
            // The dividend msb is preloaded into R, so the first trial
            // subtract already works on the top bit.
            r_q          <= {9'd0, dividend[7]};
            a_q          <= {dividend[6:0], 1'b0};
            d_q          <= divisor;
            q_q          <= 8'd0;
            cnt_q        <= 4'd0;
            result_valid <= 1'b0;
            div_by_zero  <= (divisor == 8'd0);
        end else if (shift) begin
            r_q <= {r_next[8:0], a_q[7]};
            a_q <= {a_q[6:0], 1'b0};
            q_q <= {q_q[6:0], inbit};
            if (cnt_q != CNT_DONE) begin
                cnt_q <= cnt_q + 4'd1;
            end
            // The final remainder is the restored/kept R before the last
            // shift, so it is taken from r_next and not from r_q.
            if (cnt_q == LAST_BIT) begin
                quotient     <= {q_q[6:0], inbit};
                remainder    <= r_next[7:0];
                result_valid <= 1'b1;
            end
        end else begin
            r_q <= r_next;
        end
    end

endmodule

// File: tb/tb_divider_datapath.sv
module tb_divider_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       sign;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       result_valid;
    logic       div_by_zero;

    divider_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .add          (add),
        .shift        (shift),
        .inbit        (inbit),
        .sel          (sel),
        .dividend     (dividend),
        .divisor      (divisor),
        .sign         (sign),
        .quotient     (quotient),
        .remainder    (remainder),
        .result_valid (result_valid),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] cur_a;
    logic [7:0] cur_d;
    int         pr;
    int         iter;
    logic [7:0] held_q;
    logic [7:0] held_r;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        load  = 1'b0;
        add   = 1'b0;
        shift = 1'b0;
        inbit = 1'b0;
        sel   = 2'd0;
    endtask

    // Load operands; optional junk on the other controls must be ignored.
    task automatic do_load(input logic [7:0] a, input logic [7:0] d,
                           input logic sh, input logic [1:0] s);
        exp_t e;
        // An unfinished division is aborted by this load.
        if (sb.size() != 0) void'(sb.pop_back());
        load     = 1'b1;
        shift    = sh;
        sel      = s;
        add      = sh;
        inbit    = sh;
        dividend = a;
        divisor  = d;
        tick();
        idle_inputs();
        e.q   = (d != 8'd0) ? 8'(a / d) : 8'hFF;
        e.r   = (d != 8'd0) ? 8'(a % d) : a;
        e.dbz = (d == 8'd0);
        sb.push_back(e);
        cur_a = a;
        cur_d = d;
        pr    = 0;
        iter  = 0;
        chk("load_rv",   16'(result_valid), 16'd0);
        chk("load_dbz",  16'(div_by_zero),  16'(d == 8'd0));
        chk("load_sign", 16'(sign),         16'd0);
    endtask

    // One quotient bit by the two-cycle protocol, checked against long division.
    task automatic iterate;
        int   bi;
        logic neg;
        exp_t e;
        bi  = 7 - iter;
        pr  = (pr * 2) + int'(cur_a[bi]);
        neg = (pr < int'(cur_d));
        sel   = 2'd1;
        add   = 1'b0;
        shift = 1'b0;
        tick();
        chk("trial_sign", 16'(sign), 16'(neg));
        if (sign) begin
            sel   = 2'd1;
            add   = 1'b1;
            inbit = 1'b0;
        end else begin
            sel   = 2'd3;
            inbit = 1'b1;
        end
        shift = 1'b1;
        if (!neg) pr = pr - int'(cur_d);
        tick();
        idle_inputs();
        iter++;
        if (iter < 8) begin
            chk("rv_early", 16'(result_valid), 16'd0);
        end else begin
            chk("rv_done", 16'(result_valid), 16'd1);
            if (sb.size() == 0) begin
                chk("sb_empty", 16'd1, 16'(sb.size()));
            end else begin
                e = sb.pop_front();
                chk("quotient",    16'(quotient),    16'(e.q));
                chk("remainder",   16'(remainder),   16'(e.r));
                chk("div_by_zero", 16'(div_by_zero), 16'(e.dbz));
            end
        end
    endtask

    task automatic divide(input logic [7:0] a, input logic [7:0] d);
        do_load(a, d, 1'b0, 2'd0);
        for (int k = 0; k < 8; k++) iterate();
    endtask

    initial begin
        idle_inputs();
        dividend = 8'hAA;
        divisor  = 8'h00;
        // Reset must win over a simultaneous load.
        reset = 1'b0;
        load  = 1'b1;
        tick();
        tick();
        chk("rst_sign", 16'(sign),         16'd0);
        chk("rst_q",    16'(quotient),     16'd0);
        chk("rst_r",    16'(remainder),    16'd0);
        chk("rst_rv",   16'(result_valid), 16'd0);
        chk("rst_dbz",  16'(div_by_zero),  16'd0);
        load  = 1'b0;
        reset = 1'b1;
        tick();

        divide(8'd100, 8'd7);
        divide(8'd255, 8'd16);
        divide(8'd0,   8'd5);
        divide(8'd200, 8'd0);
        divide(8'd7,   8'd100);
        divide(8'd255, 8'd1);

        // A load with shift/sel/add/inbit asserted must not shift.
        do_load(8'd100, 8'd7, 1'b1, 2'd1);
        for (int k = 0; k < 8; k++) iterate();

        // Abort mid-division, then finish a fresh one and over-shift it.
        do_load(8'd100, 8'd7, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) iterate();
        do_load(8'd9, 8'd3, 1'b0, 2'd0);
        for (int k = 0; k < 8; k++) iterate();
        held_q = 8'd3;
        held_r = 8'd0;
        for (int k = 0; k < 3; k++) begin
            sel   = 2'd3;
            shift = 1'b1;
            inbit = 1'b1;
            tick();
            idle_inputs();
            chk("extra_q",  16'(quotient),     16'(held_q));
            chk("extra_r",  16'(remainder),    16'(held_r));
            chk("extra_rv", 16'(result_valid), 16'd1);
        end

        // Reset mid-division with load asserted.
        do_load(8'd100, 8'd7, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) iterate();
        reset    = 1'b0;
        load     = 1'b1;
        dividend = 8'd55;
        divisor  = 8'd0;
        tick();
        sb.delete();
        chk("mid_rst_sign", 16'(sign),         16'd0);
        chk("mid_rst_q",    16'(quotient),     16'd0);
        chk("mid_rst_r",    16'(remainder),    16'd0);
        chk("mid_rst_rv",   16'(result_valid), 16'd0);
        chk("mid_rst_dbz",  16'(div_by_zero),  16'd0);
        reset = 1'b1;
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            sel = 2'(k);
            tick();
            chk("post_rst_rv",   16'(result_valid), 16'd0);
            chk("post_rst_q",    16'(quotient),     16'd0);
            chk("post_rst_sign", 16'(sign),         16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
